jump_encoder: RTL and testbench
===============================

Name: jump_encoder

Overview:
- Converts an absolute jump target back into a MIPS J-format instruction word {opcode, instr_index}. This is the inverse of the jump-address composition {PC+4[31:28], index, 2'b00}.
- Checks that the target is word-aligned and lies in the same 256 MB region as PC+4.
- Two-stage valid/ready pipeline with full throughput, backpressure, synchronous flush and a saturating error counter.
- Used by the self-modifying/trampoline generator and the instruction-patch path feeding instruction memory.

Parameters:
- OP_J, 6'h02, opcode emitted when in_link=0
- OP_JAL, 6'h03, opcode emitted when in_link=1
- CNT_W, 8, width of err_count

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of both pipeline stages
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid&in_ready
- in_pc  input  32  address of the jump instruction itself
- in_target  input  32  desired absolute jump target
- in_link  input  1  1=JAL, 0=J
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts when out_valid&out_ready
- out_instr  output  32  {opcode[5:0], instr_index[25:0]}
- out_err_align  output  1  in_target[1:0]!=0
- out_err_region  output  1  in_target[31:28] != (in_pc+4)[31:28]
- err_count  output  CNT_W  saturating count of errored results

Behaviour:
- Reset (rst_n=0, async): s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err_*=0, err_count=0. Reset mid-transfer discards all in-flight entries.
- Stage 1 (on accept) registers:
  - pc4 = in_pc + 32'd4, modulo 2^32. Example: 0xFFFFFFFC gives 0x00000000, region 0.
  - index = in_target[27:2]
  - opcode selected by in_link
  - err_align = |in_target[1:0]
  - err_region = in_target[31:28] != pc4[31:28]
- Stage 2 registers out_instr = {opcode, index} and both error flags.
  - Fields are always emitted, even when erroneous: index is taken from in_target[27:2], and the low bits are ignored.
- Latency: accept at edge N, out_valid=1 after edge N+1 (2 register stages). Throughput is 1 per cycle while out_ready=1.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | out_ready)
  - s1_load = in_valid & in_ready
  - in_ready = !s1_valid | s2_load. This is combinational from out_ready; no combinational path exists from in_valid to out_valid.
- Stall: with out_valid=1 and out_ready=0, out_instr and the error flags hold stable. Both stages fill, then in_ready=0.
- Simultaneous pop and push at full: allowed, with no bubble inserted.
- flush=1 at an edge:
  - s1_valid and s2_valid go to 0.
  - Any same-cycle accept is discarded.
  - in_ready is still driven normally, so an accept may be signalled but the entry is dropped.
  - err_count is not cleared.
  - flush has priority over loads.
- err_count:
  - +1 on each handshake (out_valid&out_ready) whose err_align|err_region=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Not incremented during flush.
- out_instr bits are don't-care while out_valid=0 but must not be X after reset.

Optional Feature:
- Macro: JUMP_ENCODER_DROP_ERR_EN.
- Defined:
  - An entry reaching stage 2 with any error flag set is consumed internally without asserting out_valid. Its slot frees the next cycle regardless of out_ready.
  - err_count increments once, at the cycle the entry is dropped.
  - out_err_* always read 0 when out_valid=1.
- Undefined: errored entries are presented normally with flags set, and counted on handshake.

Test Plan:
- Basic J: pc=0x00400000, target=0x00400100, link=0, out_ready=1. out_instr=0x08100040 two cycles after accept; flags 0.
- JAL wrap: pc=0xFFFFFFFC, target=0x00000010, link=1. pc4=0, so out_instr=0x0C000004 and err_region=0. Then pc=0x0FFFFFFC, target=0x10000000 gives region ok (pc4=0x10000000).
- Errors:
  - pc=0x00400000, target=0x10400002 gives err_align=1, err_region=1, out_instr=0x08100000, err_count=1.
  - With JUMP_ENCODER_DROP_ERR_EN defined, out_valid stays 0 and err_count=1.
- Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles.
  - in_ready drops after the 2nd accept.
  - out_instr is held stable during the stall.
  - After release, all 4 results emerge in order, one per cycle, with no loss or duplication.
- Flush/reset:
  - With both stages full, assert flush for 1 cycle. Next cycle out_valid=0 and in_ready=1.
  - Separately, pulse rst_n low mid-stream with err_count=5. All outputs clear to 0 asynchronously, before the next clock edge.
- Saturation: CNT_W=2, 5 errored handshakes. err_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/jump_encoder.sv
`default_nettype none
// ============================================================================
// Module   : jump_encoder
// Purpose  : Re-encodes an absolute jump target as a MIPS J/JAL word, flagging
//            misaligned and out-of-region targets. Two-stage valid/ready pipe.
// Options  : JUMP_ENCODER_DROP_ERR_EN - swallow errored entries at stage 2.
// Revision : 1.0 - initial release
// ============================================================================
module jump_encoder #(
    parameter logic [5:0] OP_J   = 6'h02,
    parameter logic [5:0] OP_JAL = 6'h03,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_target,
    input  logic             in_link,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err_align,
    output logic             out_err_region,
    output logic [CNT_W-1:0] err_count
);

    logic             s1_valid_q, s1_valid_d;
    logic [5:0]       s1_op_q;
    logic [25:0]      s1_idx_q;
    logic             s1_ea_q;
    logic             s1_er_q;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_instr_q;
    logic             s2_ea_q;
    logic             s2_er_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      w_pc4;
    logic             w_unused_pc4_lo;
    logic             w_in_ea;
    logic             w_in_er;
    logic             w_s2_err;
    logic             w_s2_pop;
    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_out_valid;
    logic             w_cnt_evt;

    // The region is taken from PC+4 (delay slot), wrapping modulo 2^32.
    assign w_pc4           = in_pc + 32'd4;
    assign w_unused_pc4_lo = ^w_pc4[27:0];
    assign w_in_ea         = |in_target[1:0];
    assign w_in_er         = in_target[31:28] != w_pc4[31:28];

    assign w_s2_err = s2_ea_q | s2_er_q;

`ifdef JUMP_ENCODER_DROP_ERR_EN
    // Errored entries leave stage 2 on their own, independent of the consumer.
    assign w_s2_pop    = s2_valid_q & (out_ready | w_s2_err);
    assign w_out_valid = s2_valid_q & ~w_s2_err;
    assign w_cnt_evt   = s2_valid_q & w_s2_err;
`else
    assign w_s2_pop    = s2_valid_q & out_ready;
    assign w_out_valid = s2_valid_q;
    assign w_cnt_evt   = w_s2_pop & w_s2_err;
`endif

    assign w_s2_load = s1_valid_q & (~s2_valid_q | w_s2_pop);
    assign in_ready  = ~s1_valid_q | w_s2_load;
    assign w_s1_load = in_valid & in_ready;

    assign out_valid      = w_out_valid;
    assign out_instr      = s2_instr_q;
    assign out_err_align  = s2_ea_q & w_out_valid;
    assign out_err_region = s2_er_q & w_out_valid;
    assign err_count      = cnt_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        cnt_d      = cnt_q;

        // Flush wins over any load, including a same-cycle accept.
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (w_s1_load) begin
                s1_valid_d = 1'b1;
            end else if (w_s2_load) begin
                s1_valid_d = 1'b0;
            end

            if (w_s2_load) begin
                s2_valid_d = 1'b1;
            end else if (w_s2_pop) begin
                s2_valid_d = 1'b0;
            end

            if (w_cnt_evt && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 6'd0;
            s1_idx_q   <= 26'd0;
            s1_ea_q    <= 1'b0;
            s1_er_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= 32'd0;
            s2_ea_q    <= 1'b0;
            s2_er_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            cnt_q      <= cnt_d;
            if (w_s1_load) begin
                s1_op_q  <= in_link ? OP_JAL : OP_J;
                s1_idx_q <= in_target[27:2];
                s1_ea_q  <= w_in_ea;
                s1_er_q  <= w_in_er;
            end
            if (w_s2_load) begin
                s2_instr_q <= {s1_op_q, s1_idx_q};
                s2_ea_q    <= s1_ea_q;
                s2_er_q    <= s1_er_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jump_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_encoder
// Purpose  : Self-checking bench for jump_encoder (wide and CNT_W=2 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jump_encoder;

`ifdef JUMP_ENCODER_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_link, out_ready;
    logic [31:0] in_pc, in_target;

    wire         in_ready, out_valid, out_err_align, out_err_region;
    wire [31:0]  out_instr;
    wire [7:0]   err_count;
    wire         in_ready_n, out_valid_n, out_err_align_n, out_err_region_n;
    wire [31:0]  out_instr_n;
    wire [1:0]   err_count_n;

    always #5 clk = ~clk;

    jump_encoder u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_target(in_target), .in_link(in_link),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err_align(out_err_align), .out_err_region(out_err_region),
        .err_count(err_count)
    );

    jump_encoder #(.CNT_W(2)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_n),
        .in_pc(in_pc), .in_target(in_target), .in_link(in_link),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_instr(out_instr_n),
        .out_err_align(out_err_align_n), .out_err_region(out_err_region_n),
        .err_count(err_count_n)
    );

    typedef struct {
        logic [31:0] instr;
        bit          ea;
        bit          er;
        int          tag;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        link;
        logic [31:0] exp_instr;
        bit          exp_ea;
        bit          exp_er;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    ent_t        mq[$];
    int          cyc = 0;
    int          m_cnt_w = 0;
    int          m_cnt_n = 0;
    bit          last_acc;
    bit          last_pop;
    logic [31:0] last_pop_instr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Encoding rules written as plain arithmetic on the target and PC+4.
    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] tgt, input logic link);
        ent_t        e;
        logic [31:0] pc4;
        pc4     = pc + 32'd4;
        e.instr = ((link ? 32'd3 : 32'd2) << 26) | ((tgt >> 2) & 32'h03FF_FFFF);
        e.ea    = (tgt % 4) != 0;
        e.er    = (tgt >> 28) != (pc4 >> 28);
        e.tag   = 0;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cnt_w = 0;
        m_cnt_n = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] tgt, input logic link, input logic v);
        in_pc     = pc;
        in_target = tgt;
        in_link   = link;
        in_valid  = v;
    endtask

    // One clock: compare against the queue model, then advance both.
    task automatic tick();
        bit   vis, err, m_ov, m_rdy, pop, push;
        ent_t e;
        @(negedge clk);
        vis   = (mq.size() > 0) && (cyc >= mq[0].tag + 1);
        err   = vis && (mq[0].ea || mq[0].er);
        m_ov  = vis && !(DROP && err);
        m_rdy = (mq.size() < 2) || out_ready || (DROP && err);
        pop   = vis && (out_ready || (DROP && err));
        push  = in_valid && m_rdy;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_err_align", {31'd0, out_err_align}, {31'd0, mq[0].ea});
            chk("out_err_region", {31'd0, out_err_region}, {31'd0, mq[0].er});
        end
        chk("err_count", {24'd0, err_count}, m_cnt_w);
        chk("err_count_n", {30'd0, err_count_n}, m_cnt_n);
        last_acc       = push;
        last_pop       = out_valid && out_ready;
        last_pop_instr = out_instr;
        e              = mk(in_pc, in_target, in_link);
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (pop) begin
                if (err) begin
                    if (m_cnt_w < 255) m_cnt_w++;
                    if (m_cnt_n < 3) m_cnt_n++;
                end
                void'(mq.pop_front());
            end
            if (push) begin
                e.tag = cyc + 1;
                mq.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    vec_t        vecs[8];
    int          sat_seq[5];
    logic [31:0] bp_tgt[4];
    logic [31:0] popped[4];

    initial begin
        logic [31:0] held, pc, pc4, rnd;
        bit          have;
        int          k, got;

        vecs[0] = '{32'h0040_0000, 32'h0040_0100, 1'b0, 32'h0810_0040, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFC, 32'h0000_0010, 1'b1, 32'h0C00_0004, 1'b0, 1'b0};
        vecs[2] = '{32'h0FFF_FFFC, 32'h1000_0000, 1'b0, 32'h0800_0000, 1'b0, 1'b0};
        vecs[3] = '{32'h0040_0000, 32'h1040_0002, 1'b0, 32'h0810_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h0040_0000, 32'h0FFF_FFFC, 1'b1, 32'h0FFF_FFFF, 1'b0, 1'b0};
        vecs[5] = '{32'h2000_0000, 32'h3000_0001, 1'b1, 32'h0C00_0000, 1'b1, 1'b1};
        vecs[6] = '{32'h0FFF_FFF8, 32'h0FFF_FFF0, 1'b0, 32'h0BFF_FFFC, 1'b0, 1'b0};
        vecs[7] = '{32'h0FFF_FFF8, 32'h1000_0000, 1'b0, 32'h0800_0000, 1'b0, 1'b1};
        sat_seq = '{1, 2, 3, 3, 3};
        bp_tgt  = '{32'h0040_0010, 32'h0040_0020, 32'h0040_0030, 32'h0040_0040};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        #2;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_instr", out_instr, 32'd0);
        chk("rst err_flags", {30'd0, out_err_align, out_err_region}, 32'd0);
        chk("rst err_count", {24'd0, err_count}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);

        // Single-request table, result visible after the second edge.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pc, vecs[i].tgt, vecs[i].link, 1'b1);
            tick();
            in_valid = 1'b0;
            tick();
            #2;
            if (DROP && (vecs[i].exp_ea || vecs[i].exp_er)) begin
                chk($sformatf("vec%0d dropped", i), {31'd0, out_valid}, 32'd0);
            end else begin
                chk($sformatf("vec%0d valid", i), {31'd0, out_valid}, 32'd1);
                chk($sformatf("vec%0d instr", i), out_instr, vecs[i].exp_instr);
                chk($sformatf("vec%0d flags", i), {30'd0, out_err_align, out_err_region},
                    {30'd0, vecs[i].exp_ea, vecs[i].exp_er});
            end
            tick();
        end

        // Error counting with saturation on the CNT_W=2 copy, then async reset.
        rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'h0040_0000, 32'h1040_0002, 1'b0, 1'b1);
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            #2;
            chk($sformatf("sat_n step%0d", i), {30'd0, err_count_n}, sat_seq[i]);
            chk($sformatf("sat_w step%0d", i), {24'd0, err_count}, i + 1);
        end
        out_ready = 1'b0;
        drive(32'h0040_0000, 32'h0040_0200, 1'b0, 1'b1);
        tick();
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async out_instr", out_instr, 32'd0);
        chk("async err_count", {24'd0, err_count}, 32'd0);
        chk("async err_flags", {30'd0, out_err_align, out_err_region}, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Flush with both stages full and a same-cycle accept.
        out_ready = 1'b0;
        drive(32'h0040_0000, 32'h0040_0300, 1'b1, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #2;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        tick();

        // Backpressure: four back-to-back requests, five stalled cycles.
        out_ready = 1'b0; k = 0; have = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(32'h0040_0000, bp_tgt[k < 4 ? k : 3], 1'b0, k < 4);
            tick();
            if (last_acc) k++;
            if (out_valid) begin
                if (!have) begin
                    held = out_instr;
                    have = 1'b1;
                end else begin
                    chk("stall hold", out_instr, held);
                end
            end
        end
        chk("bp accepted", k, 2);
        chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 4; c++) begin
            drive(32'h0040_0000, bp_tgt[k < 4 ? k : 3], 1'b0, k < 4);
            tick();
            if (last_acc) k++;
            if (last_pop && got < 4) begin
                popped[got] = last_pop_instr;
                got++;
            end
        end
        chk("bp pop count", got, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp order%0d", i), popped[i], mk(32'h0040_0000, bp_tgt[i], 1'b0).instr);
        end
        in_valid = 1'b0;
        tick();

        // Randomised traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            pc  = $urandom;
            pc4 = pc + 32'd4;
            rnd = $urandom;
            if ($urandom_range(1, 0) == 1) drive(pc, {pc4[31:28], rnd[27:2], 2'b00}, rnd[0], $urandom_range(9, 0) < 7);
            else drive(pc, rnd, rnd[1], $urandom_range(9, 0) < 7);
            out_ready = $urandom_range(9, 0) < 6;
            flush     = $urandom_range(15, 0) == 0;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
